// File: rtl/multicycle_pkg.sv
// Shared definitions for the multicycle LEGv8 control unit: opcode patterns,
// state and instruction-class encodings, ALUOp classes and the steering table.
package multicycle_pkg;

    localparam logic [10:0] OP_LDUR = 11'b11111000010;
    localparam logic [10:0] OP_STUR = 11'b11111000000;
    localparam logic [10:0] OP_ADD  = 11'b10001011000;
    localparam logic [10:0] OP_SUB  = 11'b11001011000;
    localparam logic [10:0] OP_AND  = 11'b10001010000;
    localparam logic [10:0] OP_ORR  = 11'b10101010000;
    localparam logic [10:0] OP_CBZ  = 11'b10110100???;
    localparam logic [10:0] OP_B    = 11'b000101?????;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_CBZ   = 2'b01;
    localparam logic [1:0] ALUOP_RTYPE = 2'b10;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4,
        ST_FAULT  = 3'd7
    } state_e;

    typedef enum logic [2:0] {
        CLS_NONE  = 3'd0,
        CLS_LDUR  = 3'd1,
        CLS_STUR  = 3'd2,
        CLS_RTYPE = 3'd3,
        CLS_CBZ   = 3'd4,
        CLS_B     = 3'd5
    } iclass_e;

    typedef struct packed {
        logic       reg2loc;
        logic       alusrc;
        logic [1:0] aluop;
        logic       memtoreg;
    } steer_t;

    // CLS_NONE (no instruction in flight) maps to all-zero steering.
    function automatic steer_t steer_of(input iclass_e cls);
        steer_t s;
        s = '0;
        case (cls)
            CLS_LDUR:  begin s.alusrc = 1'b1; s.aluop = ALUOP_ADD; s.memtoreg = 1'b1; end
            CLS_STUR:  begin s.reg2loc = 1'b1; s.alusrc = 1'b1; s.aluop = ALUOP_ADD; end
            CLS_RTYPE: begin s.aluop = ALUOP_RTYPE; end
            CLS_CBZ:   begin s.reg2loc = 1'b1; s.aluop = ALUOP_CBZ; end
            CLS_B:     begin s.aluop = ALUOP_ADD; end
            default:   begin s = '0; end
        endcase
        return s;
    endfunction

endpackage

// File: rtl/mc_opcode_decoder.sv
// Combinational opcode classifier: Opcode -> {legal, instruction class}.
// Priority casez; CBZ and B match on their fixed high bits only.
module mc_opcode_decoder
    import multicycle_pkg::*;
#(
    parameter int OPCODE_W = 11
) (
    input  logic [OPCODE_W-1:0] opcode_i,
    output logic                legal_o,
    output logic [2:0]          class_o
);

    // Priority decode of the opcode field into an instruction class.
    always_comb begin
        legal_o = 1'b1;
        class_o = CLS_NONE;
        casez (opcode_i)
            OP_LDUR: class_o = CLS_LDUR;
            OP_STUR: class_o = CLS_STUR;
            OP_ADD:  class_o = CLS_RTYPE;
            OP_SUB:  class_o = CLS_RTYPE;
            OP_AND:  class_o = CLS_RTYPE;
            OP_ORR:  class_o = CLS_RTYPE;
            OP_CBZ:  class_o = CLS_CBZ;
            OP_B:    class_o = CLS_B;
            default: begin
                legal_o = 1'b0;
                class_o = CLS_NONE;
            end
        endcase
    end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle LEGv8 control FSM (FETCH/DECODE/EXEC/MEM/WB/FAULT) with memory
// wait timeout. Optional retired-instruction counter: define MC_PERF_COUNT_EN.
module multicycle_control
    import multicycle_pkg::*;
#(
    parameter int OPCODE_W    = 11,
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = $clog2(MEM_TIMEOUT + 1)
) (
    input  logic                CLK,
    input  logic                Reset,
    input  logic [OPCODE_W-1:0] Opcode,
    input  logic                MemReady,
    input  logic                Zero,
    output logic                InstrReq,
    output logic                IRWrite,
    output logic                PCWrite,
    output logic                Reg2Loc,
    output logic                ALUSrc,
    output logic                MemToReg,
    output logic                RegWrite,
    output logic                MemRead,
    output logic                MemWrite,
    output logic                Branch,
    output logic                Uncondbranch,
    output logic [1:0]          ALUOp,
    output logic                Fault,
    output logic [2:0]          State
`ifdef MC_PERF_COUNT_EN
    ,
    output logic [31:0]         RetiredCount
`endif
);

    localparam int            CW          = (CNT_W > 0) ? CNT_W : 1;
    localparam logic          TIMEOUT_EN  = (MEM_TIMEOUT > 0) ? 1'b1 : 1'b0;
    localparam logic [CW-1:0] CNT_LIMIT   = CW'((MEM_TIMEOUT > 0) ? (MEM_TIMEOUT - 1) : 0);
    localparam logic [CW-1:0] CNT_MAX     = '1;

    state_e        state_q, state_d;
    iclass_e       class_q, class_d;
    logic [CW-1:0] cnt_q, cnt_d;

    logic          dec_legal;
    logic [2:0]    dec_class_raw;
    iclass_e       dec_class;
    iclass_e       steer_cls;
    steer_t        steer;
    logic          wait_expired;

    logic instr_req, ir_write, pc_write, reg_write;
    logic mem_read, mem_write, branch, uncond, fault;

    mc_opcode_decoder #(
        .OPCODE_W (OPCODE_W)
    ) u_dec (
        .opcode_i (Opcode),
        .legal_o  (dec_legal),
        .class_o  (dec_class_raw)
    );

    // Limit is checked one count early so the FAULT transition lands after
    // exactly MEM_TIMEOUT low cycles; MemReady high always takes priority.
    always_comb begin
        dec_class    = iclass_e'(dec_class_raw);
        wait_expired = TIMEOUT_EN && !MemReady && (cnt_q == CNT_LIMIT);
    end

    // Next-state and control-strobe logic.
    always_comb begin
        state_d   = state_q;
        class_d   = class_q;
        steer_cls = CLS_NONE;
        instr_req = 1'b0;
        ir_write  = 1'b0;
        pc_write  = 1'b0;
        reg_write = 1'b0;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        branch    = 1'b0;
        uncond    = 1'b0;
        fault     = 1'b0;
        case (state_q)
            ST_FETCH: begin
                instr_req = 1'b1;
                if (MemReady) begin
                    ir_write = 1'b1;
                    pc_write = 1'b1;
                    state_d  = ST_DECODE;
                end else if (wait_expired) begin
                    state_d = ST_FAULT;
                end else begin
                    state_d = ST_FETCH;
                end
            end
            ST_DECODE: begin
                if (dec_legal) begin
                    steer_cls = dec_class;
                    class_d   = dec_class;
                    state_d   = ST_EXEC;
                end else begin
                    state_d = ST_FAULT;
                end
            end
            ST_EXEC: begin
                steer_cls = class_q;
                case (class_q)
                    CLS_RTYPE: state_d = ST_WB;
                    CLS_LDUR:  state_d = ST_MEM;
                    CLS_STUR:  state_d = ST_MEM;
                    CLS_CBZ: begin
                        branch   = 1'b1;
                        pc_write = Zero;
                        state_d  = ST_FETCH;
                    end
                    CLS_B: begin
                        uncond   = 1'b1;
                        pc_write = 1'b1;
                        state_d  = ST_FETCH;
                    end
                    default: state_d = ST_FAULT;
                endcase
            end
            ST_MEM: begin
                steer_cls = class_q;
                case (class_q)
                    CLS_LDUR: begin
                        mem_read = 1'b1;
                        if (MemReady) begin
                            state_d = ST_WB;
                        end else if (wait_expired) begin
                            state_d = ST_FAULT;
                        end else begin
                            state_d = ST_MEM;
                        end
                    end
                    CLS_STUR: begin
                        mem_write = 1'b1;
                        if (MemReady) begin
                            state_d = ST_FETCH;
                        end else if (wait_expired) begin
                            state_d = ST_FAULT;
                        end else begin
                            state_d = ST_MEM;
                        end
                    end
                    default: state_d = ST_FAULT;
                endcase
            end
            ST_WB: begin
                steer_cls = class_q;
                reg_write = 1'b1;
                state_d   = ST_FETCH;
            end
            ST_FAULT: begin
                fault   = 1'b1;
                state_d = ST_FAULT;
            end
            default: begin
                fault   = 1'b1;
                state_d = ST_FAULT;
            end
        endcase
        steer = steer_of(steer_cls);
    end

    // Wait counter: restarts on any state change, counts low-MemReady cycles.
    always_comb begin
        if (state_d != state_q) begin
            cnt_d = '0;
        end else if ((state_q == ST_FETCH || state_q == ST_MEM) && !MemReady && cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + CW'(1);
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Outputs are forced low while Reset is asserted, even though FETCH
    // would otherwise raise InstrReq.
    always_comb begin
        if (Reset) begin
            InstrReq     = 1'b0;
            IRWrite      = 1'b0;
            PCWrite      = 1'b0;
            Reg2Loc      = 1'b0;
            ALUSrc       = 1'b0;
            MemToReg     = 1'b0;
            RegWrite     = 1'b0;
            MemRead      = 1'b0;
            MemWrite     = 1'b0;
            Branch       = 1'b0;
            Uncondbranch = 1'b0;
            ALUOp        = 2'b00;
            Fault        = 1'b0;
        end else begin
            InstrReq     = instr_req;
            IRWrite      = ir_write;
            PCWrite      = pc_write;
            Reg2Loc      = steer.reg2loc;
            ALUSrc       = steer.alusrc;
            MemToReg     = steer.memtoreg;
            RegWrite     = reg_write;
            MemRead      = mem_read;
            MemWrite     = mem_write;
            Branch       = branch;
            Uncondbranch = uncond;
            ALUOp        = steer.aluop;
            Fault        = fault;
        end
        State = state_q;
    end

    // State, class and wait-counter registers.
    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            state_q <= ST_FETCH;
            class_q <= CLS_NONE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            class_q <= class_d;
            cnt_q   <= cnt_d;
        end
    end

`ifdef MC_PERF_COUNT_EN
    logic [31:0] retired_q, retired_d;

    // Retire on every return to FETCH from an executing state.
    always_comb begin
        if (state_d == ST_FETCH && (state_q == ST_EXEC || state_q == ST_MEM || state_q == ST_WB)) begin
            retired_d = retired_q + 32'd1;
        end else begin
            retired_d = retired_q;
        end
        RetiredCount = retired_q;
    end

    // Retired-instruction counter register.
    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            retired_q <= 32'd0;
        end else begin
            retired_q <= retired_d;
        end
    end
`endif

endmodule

// File: tb/tb_multicycle_control.sv
// Table-driven bench for multicycle_control (MEM_TIMEOUT=4) plus a sticky-fault
// sequence. RetiredCount is also checked when MC_PERF_COUNT_EN is defined.
module tb_multicycle_control;

    logic        CLK;
    logic        Reset;
    logic [10:0] Opcode;
    logic        MemReady;
    logic        Zero;
    logic        InstrReq, IRWrite, PCWrite, Reg2Loc, ALUSrc, MemToReg, RegWrite;
    logic        MemRead, MemWrite, Branch, Uncondbranch, Fault;
    logic [1:0]  ALUOp;
    logic [2:0]  State;
`ifdef MC_PERF_COUNT_EN
    logic [31:0] RetiredCount;
`endif

    multicycle_control #(
        .OPCODE_W    (11),
        .MEM_TIMEOUT (4)
    ) dut (
        .CLK          (CLK),
        .Reset        (Reset),
        .Opcode       (Opcode),
        .MemReady     (MemReady),
        .Zero         (Zero),
        .InstrReq     (InstrReq),
        .IRWrite      (IRWrite),
        .PCWrite      (PCWrite),
        .Reg2Loc      (Reg2Loc),
        .ALUSrc       (ALUSrc),
        .MemToReg     (MemToReg),
        .RegWrite     (RegWrite),
        .MemRead      (MemRead),
        .MemWrite     (MemWrite),
        .Branch       (Branch),
        .Uncondbranch (Uncondbranch),
        .ALUOp        (ALUOp),
        .Fault        (Fault),
        .State        (State)
`ifdef MC_PERF_COUNT_EN
        ,
        .RetiredCount (RetiredCount)
`endif
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    localparam logic [10:0] O_LDUR = 11'b11111000010;
    localparam logic [10:0] O_STUR = 11'b11111000000;
    localparam logic [10:0] O_ADD  = 11'b10001011000;
    localparam logic [10:0] O_SUB  = 11'b11001011000;
    localparam logic [10:0] O_AND  = 11'b10001010000;
    localparam logic [10:0] O_ORR  = 11'b10101010000;
    localparam logic [10:0] O_CBZ  = 11'b10110100101;
    localparam logic [10:0] O_B    = 11'b00010110011;
    localparam logic [10:0] O_ILL  = 11'b00000000000;

    // Expected output bundle bits: {InstrReq,IRWrite,PCWrite,Reg2Loc,ALUSrc,
    // MemToReg,RegWrite,MemRead,MemWrite,Branch,Uncondbranch,ALUOp[1:0],Fault}
    localparam logic [13:0] NONE  = 14'h0000;
    localparam logic [13:0] IREQ  = 14'h2000;
    localparam logic [13:0] IRW   = 14'h1000;
    localparam logic [13:0] PCW   = 14'h0800;
    localparam logic [13:0] R2L   = 14'h0400;
    localparam logic [13:0] ALUS  = 14'h0200;
    localparam logic [13:0] M2R   = 14'h0100;
    localparam logic [13:0] REGW  = 14'h0080;
    localparam logic [13:0] MRD   = 14'h0040;
    localparam logic [13:0] MWR   = 14'h0020;
    localparam logic [13:0] BR    = 14'h0010;
    localparam logic [13:0] UNC   = 14'h0008;
    localparam logic [13:0] AOP10 = 14'h0004;
    localparam logic [13:0] AOP01 = 14'h0002;
    localparam logic [13:0] FLT   = 14'h0001;
    localparam logic [13:0] FD    = IREQ | IRW | PCW;

    typedef struct {
        logic        rst;
        logic [10:0] op;
        logic        mr;
        logic        z;
        logic [2:0]  st;
        logic [13:0] exp;
    } vec_t;

    vec_t vecs[$];
    int   checks = 0;
    int   errors = 0;

    function automatic logic [13:0] obs();
        return {InstrReq, IRWrite, PCWrite, Reg2Loc, ALUSrc, MemToReg, RegWrite,
                MemRead, MemWrite, Branch, Uncondbranch, ALUOp, Fault};
    endfunction

    task automatic add(input logic rst, input logic [10:0] op, input logic mr,
                       input logic z, input logic [2:0] st, input logic [13:0] e);
        vec_t v;
        v.rst = rst; v.op = op; v.mr = mr; v.z = z; v.st = st; v.exp = e;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    task automatic add_rtype(input logic [10:0] op);
        add(1'b0, op, 1'b1, 1'b0, 3'd0, FD);
        add(1'b0, op, 1'b1, 1'b0, 3'd1, AOP10);
        add(1'b0, op, 1'b1, 1'b0, 3'd2, AOP10);
        add(1'b0, op, 1'b1, 1'b0, 3'd4, REGW | AOP10);
    endtask

    task automatic add_ldur_front();
        add(1'b0, O_LDUR, 1'b1, 1'b0, 3'd0, FD);
        add(1'b0, O_LDUR, 1'b1, 1'b0, 3'd1, ALUS | M2R);
        add(1'b0, O_LDUR, 1'b1, 1'b0, 3'd2, ALUS | M2R);
    endtask

    initial begin
        logic [31:0] exp_ret;
        logic [2:0]  prev_st;
        logic        prev_rst;

        Reset = 1'b1; Opcode = 11'd0; MemReady = 1'b0; Zero = 1'b0;

        add(1'b1, O_ADD, 1'b0, 1'b0, 3'd0, NONE);
        // R-type group, MemReady always high
        add_rtype(O_ADD);
        add_rtype(O_SUB);
        add_rtype(O_AND);
        add_rtype(O_ORR);
        // LDUR with three MemReady-low cycles in MEM
        add_ldur_front();
        for (int k = 0; k < 3; k++) add(1'b0, O_LDUR, 1'b0, 1'b0, 3'd3, MRD | ALUS | M2R);
        add(1'b0, O_LDUR, 1'b1, 1'b0, 3'd3, MRD | ALUS | M2R);
        add(1'b0, O_LDUR, 1'b1, 1'b0, 3'd4, REGW | ALUS | M2R);
        // CBZ taken, then not taken
        add(1'b0, O_CBZ, 1'b1, 1'b1, 3'd0, FD);
        add(1'b0, O_CBZ, 1'b1, 1'b1, 3'd1, R2L | AOP01);
        add(1'b0, O_CBZ, 1'b1, 1'b1, 3'd2, BR | PCW | R2L | AOP01);
        add(1'b0, O_CBZ, 1'b1, 1'b0, 3'd0, FD);
        add(1'b0, O_CBZ, 1'b1, 1'b0, 3'd1, R2L | AOP01);
        add(1'b0, O_CBZ, 1'b1, 1'b0, 3'd2, BR | R2L | AOP01);
        // STUR with one fetch wait
        add(1'b0, O_STUR, 1'b0, 1'b0, 3'd0, IREQ);
        add(1'b0, O_STUR, 1'b1, 1'b0, 3'd0, FD);
        add(1'b0, O_STUR, 1'b1, 1'b0, 3'd1, R2L | ALUS);
        add(1'b0, O_STUR, 1'b1, 1'b0, 3'd2, R2L | ALUS);
        add(1'b0, O_STUR, 1'b1, 1'b0, 3'd3, MWR | R2L | ALUS);
        // MemReady arrives on the 4th fetch wait cycle: limit loses, then B
        for (int k = 0; k < 3; k++) add(1'b0, O_B, 1'b0, 1'b0, 3'd0, IREQ);
        add(1'b0, O_B, 1'b1, 1'b0, 3'd0, FD);
        add(1'b0, O_B, 1'b1, 1'b0, 3'd1, NONE);
        add(1'b0, O_B, 1'b1, 1'b0, 3'd2, UNC | PCW);
        // MEM timeout during LDUR
        add_ldur_front();
        for (int k = 0; k < 4; k++) add(1'b0, O_LDUR, 1'b0, 1'b0, 3'd3, MRD | ALUS | M2R);
        add(1'b0, O_LDUR, 1'b0, 1'b0, 3'd7, FLT);
        add(1'b0, O_LDUR, 1'b1, 1'b0, 3'd7, FLT);
        add(1'b1, O_LDUR, 1'b0, 1'b0, 3'd0, NONE);
        // FETCH timeout
        for (int k = 0; k < 4; k++) add(1'b0, O_B, 1'b0, 1'b0, 3'd0, IREQ);
        add(1'b0, O_B, 1'b1, 1'b0, 3'd7, FLT);
        add(1'b1, O_B, 1'b1, 1'b0, 3'd0, NONE);
        // Reset mid-LDUR in MEM, then an illegal opcode
        add_ldur_front();
        add(1'b0, O_LDUR, 1'b0, 1'b0, 3'd3, MRD | ALUS | M2R);
        add(1'b1, O_LDUR, 1'b0, 1'b0, 3'd0, NONE);
        add(1'b0, O_LDUR, 1'b0, 1'b0, 3'd0, IREQ);
        add(1'b0, O_ILL, 1'b1, 1'b0, 3'd0, FD);
        add(1'b0, O_ILL, 1'b1, 1'b0, 3'd1, NONE);
        add(1'b0, O_ILL, 1'b1, 1'b0, 3'd7, FLT);

        @(posedge CLK);
        #1;
        exp_ret  = 32'd0;
        prev_st  = 3'd0;
        prev_rst = 1'b1;
        for (int i = 0; i < vecs.size(); i++) begin
            Reset    = vecs[i].rst;
            Opcode   = vecs[i].op;
            MemReady = vecs[i].mr;
            Zero     = vecs[i].z;
            if (vecs[i].rst) begin
                exp_ret = 32'd0;
            end else if (!prev_rst && vecs[i].st == 3'd0 && (prev_st == 3'd2 || prev_st == 3'd3 || prev_st == 3'd4)) begin
                exp_ret = exp_ret + 32'd1;
            end else begin
                exp_ret = exp_ret;
            end
            @(negedge CLK);
            check($sformatf("vec%0d_state", i), {29'd0, State}, {29'd0, vecs[i].st});
            check($sformatf("vec%0d_outs", i), {18'd0, obs()}, {18'd0, vecs[i].exp});
`ifdef MC_PERF_COUNT_EN
            check($sformatf("vec%0d_retired", i), RetiredCount, exp_ret);
`endif
            prev_st  = vecs[i].st;
            prev_rst = vecs[i].rst;
            @(posedge CLK);
            #1;
        end

        // Sticky FAULT: 20 cycles with MemReady and Opcode toggling
        for (int k = 0; k < 20; k++) begin
            MemReady = k[0];
            Opcode   = k[0] ? O_ADD : O_LDUR;
            @(negedge CLK);
            check($sformatf("fault_hold%0d", k), {15'd0, State, obs()}, {15'd0, 3'd7, FLT});
            @(posedge CLK);
            #1;
        end
        Reset = 1'b1;
        #1;
        check("fault_async_clear", {15'd0, State, obs()}, {15'd0, 3'd0, NONE});
        @(posedge CLK);
        #1;
        Reset    = 1'b0;
        MemReady = 1'b0;
        @(negedge CLK);
        check("post_reset_fetch", {15'd0, State, obs()}, {15'd0, 3'd0, IREQ});

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
